// File: rtl/mrd_pkg.sv
// Shared types and defaults for the minimal-residual-descent inverse sequencer.
package mrd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RES,
    S_DIR,
    S_UPD,
    S_COLOUT,
    S_DONE
  } mrd_state_t;

  localparam int MRD_M2V_LAT = 2;
  localparam int MRD_V2V_LAT = 1;
  localparam int MRD_ADD_LAT = 1;

  // The dwell counter holds at most (max_lat - 1); keep at least one bit.
  function automatic int mrd_cnt_w(input int max_lat);
    return (max_lat <= 2) ? 1 : $clog2(max_lat);
  endfunction

endpackage

// File: rtl/mrd_lat_timer.sv
// Loadable down-counter that times how long the sequencer dwells in a state.
module mrd_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mrd_inv_ctrl.sv
// Column/iteration sequencer for the MRD inverse datapath; all outputs are
// registered from the next-state decode so they only move on clk edges.
module mrd_inv_ctrl
  import mrd_pkg::*;
#(
  parameter int DIMENSION = 16,
  parameter int ITER_NUM  = 2,
  parameter int M2V_LAT   = MRD_M2V_LAT,
  parameter int V2V_LAT   = MRD_V2V_LAT,
  parameter int ADD_LAT   = MRD_ADD_LAT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  output logic                         dp_en,
  output logic                         slc_sig1,
  output logic                         slc_sig2,
  output logic [$clog2(DIMENSION)-1:0] col_idx,
  output logic [2:0]                   iter_idx,
  output logic                         col_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int CIW     = $clog2(DIMENSION);
  localparam int DIR_LAT = M2V_LAT + V2V_LAT;
  localparam int MAX_LAT = (DIR_LAT > ADD_LAT) ? DIR_LAT : ADD_LAT;
  localparam int CW      = mrd_cnt_w(MAX_LAT);

  localparam logic [2:0]     ITER_LAST = 3'(ITER_NUM - 1);
  localparam logic [CIW-1:0] COL_LAST  = CIW'(DIMENSION - 1);

  mrd_state_t     state, state_nxt;
  logic [CIW-1:0] col_nxt;
  logic [2:0]     iter_nxt;
  logic           sig1_nxt;
  logic           tmr_load;
  logic [CW-1:0]  tmr_val;
  logic           tmr_zero;

  mrd_lat_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    iter_nxt  = iter_idx;
    if (abort) begin
      state_nxt = S_IDLE;
      col_nxt   = '0;
      iter_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state_nxt = S_LOAD;
          col_nxt   = '0;
          iter_nxt  = '0;
        end
        S_LOAD: if (tmr_zero) state_nxt = S_RES;
        S_RES:  if (tmr_zero) state_nxt = S_DIR;
        S_DIR:  if (tmr_zero) state_nxt = S_UPD;
        S_UPD: if (tmr_zero) begin
          if (iter_idx == ITER_LAST) begin
            state_nxt = S_COLOUT;
          end else begin
            state_nxt = S_RES;
            iter_nxt  = iter_idx + 3'd1;
          end
        end
        S_COLOUT: if (tmr_zero) begin
          if (col_idx == COL_LAST) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_LOAD;
            col_nxt   = col_idx + 1'b1;
            iter_nxt  = '0;
          end
        end
        S_DONE: if (tmr_zero) begin
          state_nxt = S_IDLE;
          col_nxt   = '0;
          iter_nxt  = '0;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Every state is entered from a different state, so a change of state is
  // exactly a state entry and the timer reloads with (latency - 1).
  always_comb begin
    tmr_load = (state_nxt != state);
    tmr_val  = '0;
    case (state_nxt)
      S_RES:   tmr_val = CW'(M2V_LAT - 1);
      S_DIR:   tmr_val = CW'(DIR_LAT - 1);
      S_UPD:   tmr_val = CW'(ADD_LAT - 1);
      default: tmr_val = '0;
    endcase
  end

  // Mi source switches to Mi_update at the first update and stays there
  // until the next column reloads M_init.
  always_comb begin
    sig1_nxt = slc_sig1;
    if (state_nxt == S_UPD)                          sig1_nxt = 1'b1;
    else if (state_nxt == S_LOAD || state_nxt == S_IDLE) sig1_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      col_idx   <= '0;
      iter_idx  <= '0;
      dp_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      col_valid <= 1'b0;
      slc_sig1  <= 1'b0;
      slc_sig2  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      iter_idx  <= iter_nxt;
      dp_en     <= (state_nxt != S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      col_valid <= (state_nxt == S_COLOUT);
      slc_sig1  <= sig1_nxt;
      slc_sig2  <= (state_nxt == S_DIR) || (state_nxt == S_UPD);
    end
  end

endmodule

// File: tb/tb_mrd_inv_ctrl.sv
// Scoreboard bench for mrd_inv_ctrl: default-parameter instance plus a swept one.
module tb_mrd_inv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, start2, abort2;

  logic       dp_en, slc_sig1, slc_sig2, col_valid, busy, done;
  logic [3:0] col_idx;
  logic [2:0] iter_idx;
  logic       dp_en2, slc_sig12, slc_sig22, col_valid2, busy2, done2;
  logic [1:0] col_idx2;
  logic [2:0] iter_idx2;

  mrd_inv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dp_en(dp_en), .slc_sig1(slc_sig1), .slc_sig2(slc_sig2),
    .col_idx(col_idx), .iter_idx(iter_idx), .col_valid(col_valid),
    .busy(busy), .done(done)
  );

  mrd_inv_ctrl #(.DIMENSION(4), .ITER_NUM(1), .M2V_LAT(3), .V2V_LAT(2), .ADD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .dp_en(dp_en2), .slc_sig1(slc_sig12), .slc_sig2(slc_sig22),
    .col_idx(col_idx2), .iter_idx(iter_idx2), .col_valid(col_valid2),
    .busy(busy2), .done(done2)
  );

  wire [13:0] o1 = {dp_en, slc_sig1, slc_sig2, col_idx, iter_idx, col_valid, busy, done};
  wire [11:0] o2 = {dp_en2, slc_sig12, slc_sig22, col_idx2, iter_idx2, col_valid2, busy2, done2};

  typedef struct {
    int cyc;
    bit is_done;
    int col;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];
  ev_t m1, m2;

  int cyc = 0;
  int nvec = 0;
  int nmis = 0;
  int base, base2;
  int s2tab[15] = '{0,0,0,1,1,1,1,0,0,1,1,1,1,0,0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected col_valid strobes at T_col*(k+1) after the start cycle, done one later.
  task automatic push_run(input int which, input int b, input int tcol, input int dim);
    ev_t e;
    for (int k = 0; k < dim; k++) begin
      e.cyc = b + tcol * (k + 1); e.is_done = 1'b0; e.col = k;
      if (which == 1) q1.push_back(e); else q2.push_back(e);
    end
    e.cyc = b + tcol * dim + 1; e.is_done = 1'b1; e.col = 0;
    if (which == 1) q1.push_back(e); else q2.push_back(e);
  endtask

  task automatic cancel_after(input int lim);
    ev_t keep[$];
    foreach (q1[i]) if (q1[i].cyc <= lim) keep.push_back(q1[i]);
    q1 = keep;
  endtask

  always @(negedge clk) begin
    if (col_valid || done) begin
      if (q1.size() == 0) chk("dut1_unexpected_strobe", 1, 0);
      else begin
        m1 = q1.pop_front();
        chk("dut1_strobe_cycle", cyc, m1.cyc);
        chk("dut1_strobe_kind_done", done, int'(m1.is_done));
        chk("dut1_strobe_kind_colv", col_valid, int'(!m1.is_done));
        if (!m1.is_done) chk("dut1_col_idx", col_idx, m1.col);
      end
    end
  end

  always @(negedge clk) begin
    if (col_valid2 || done2) begin
      if (q2.size() == 0) chk("dut2_unexpected_strobe", 1, 0);
      else begin
        m2 = q2.pop_front();
        chk("dut2_strobe_cycle", cyc, m2.cyc);
        chk("dut2_strobe_kind_done", done2, int'(m2.is_done));
        chk("dut2_strobe_kind_colv", col_valid2, int'(!m2.is_done));
        if (!m2.is_done) chk("dut2_col_idx", col_idx2, m2.col);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs1", int'(o1), 0);
    chk("reset_outs2", int'(o2), 0);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outs1", int'(o1), 0);
      chk("idle_outs2", int'(o2), 0);
    end

    // Full run at defaults, with start pulses during busy that must be ignored.
    start = 1'b1; base = cyc;
    push_run(1, base, 14, 16);
    for (int r = 1; r <= 226; r++) begin
      @(negedge clk);
      start = (r == 50 || r == 150);
      chk("busy", busy, int'(r <= 225));
      chk("dp_en", dp_en, int'(r <= 225));
      if (r <= 15) begin
        chk("slc_sig2_col0", slc_sig2, s2tab[r-1]);
        chk("slc_sig1_col0", slc_sig1, int'(r >= 7 && r <= 14));
      end
    end
    chk("idle_after_done", int'(o1), 0);
    chk("q1_drained_run", q1.size(), 0);

    // Parameter sweep instance.
    start2 = 1'b1; base2 = cyc;
    push_run(2, base2, 12, 4);
    for (int r = 1; r <= 52; r++) begin
      @(negedge clk);
      start2 = 1'b0;
      chk("busy2", busy2, int'(r <= 49));
    end
    chk("idle2_after_done", int'(o2), 0);
    chk("q2_drained", q2.size(), 0);

    // Abort at cycle 40, restart at 41.
    start = 1'b1; base = cyc;
    push_run(1, base, 14, 16);
    for (int r = 1; r <= 41; r++) begin
      @(negedge clk);
      start = 1'b0;
      if (r == 40) abort = 1'b1;
    end
    abort = 1'b0;
    chk("abort_outs", int'(o1), 0);
    cancel_after(base + 40);
    start = 1'b1; base = cyc;
    push_run(1, base, 14, 16);

    // Reset at cycle 100 of the restarted run.
    for (int r = 1; r <= 101; r++) begin
      @(negedge clk);
      start = 1'b0;
      if (r == 100) rst = 1'b1;
    end
    rst = 1'b0;
    chk("midrun_rst_outs", int'(o1), 0);
    cancel_after(base + 100);
    repeat (200) @(negedge clk);
    chk("idle_after_rst", int'(o1), 0);
    chk("q1_drained_end", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mrd_inv_ctrl.md
# mrd_inv_ctrl

Sequencer for the minimal-residual-descent inverse datapath. It walks the datapath through every column j of the approximate inverse, running ITER_NUM refinement iterations per column. For each iteration it drives the two MUX selects (Mi source, M2V input source) and waits out the fixed latencies of the M2V, V2V and adder stages. It sits between the system-level start/done handshake and the datapath, and flags each finished column so the M_iter column can be captured.

## Interface
Parameters:
- DIMENSION, 16, matrix order = number of columns processed
- ITER_NUM, 2, refinement iterations per column (≥1)
- M2V_LAT, 2, cycles from M2V input change to valid MV (≥1)
- V2V_LAT, 1, cycles from MV/rj valid to valid fenzi/fenmu (≥1)
- ADD_LAT, 1, cycles from alpha valid to valid Mi_update (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request, sampled only in IDLE
- abort  in  1  synchronous cancel, any state
- dp_en  out  1  datapath enable (en of the datapath sub-blocks)
- slc_sig1  out  1  Mi source: 0 = M_init, 1 = Mi_update
- slc_sig2  out  1  M2V input: 0 = Mi (residual phase), 1 = rj (direction phase)
- col_idx  out  $clog2(DIMENSION)  current column; selects ej and the M_init column
- iter_idx  out  3  current iteration within the column
- col_valid  out  1  one-cycle strobe; M_iter is the final column col_idx
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle strobe at end of run

## Operation
- States: IDLE, LOAD, RES, DIR, UPD, COLOUT, DONE.
- IDLE: all outputs 0. start=1 → LOAD with col_idx=0 and iter_idx=0.
- LOAD (1 cycle): slc_sig1=0, slc_sig2=0. → RES.
- RES (M2V_LAT cycles): slc_sig2=0. A·Mi propagates and rj = ej − MV. → DIR.
- DIR (M2V_LAT+V2V_LAT cycles): slc_sig2=1. A·rj propagates, then fenzi/fenmu and alpha. → UPD.
- UPD (ADD_LAT cycles): slc_sig2=1, slc_sig1=1.
  - If iter_idx = ITER_NUM−1 → COLOUT.
  - Otherwise iter_idx+1 → RES.
- slc_sig1 is 0 from LOAD through the end of DIR of iteration 0. It is 1 from the first UPD cycle until the next LOAD.
- COLOUT (1 cycle): col_valid=1.
  - If col_idx = DIMENSION−1 → DONE.
  - Otherwise col_idx+1, iter_idx=0 → LOAD.
- DONE (1 cycle): done=1, busy=1. → IDLE, col_idx and iter_idx cleared.
- dp_en = busy.
- Dwell time in each state is set by a single down-counter. It loads (latency−1) on state entry, and the state exits when the counter reads 0.
- start is ignored while busy; no queuing.
- abort=1 in any state: next state IDLE, all counters and outputs cleared. abort has priority over start in the same cycle.
- rst has priority over abort. rst mid-run behaves as abort, and the run is lost.

## Timing
- Reset values: state IDLE. dp_en, slc_sig1, slc_sig2, col_valid, busy and done are 0. col_idx and iter_idx are 0.
- All outputs are registered and change only on clk edges.
- Cycles per iteration: T_it = 2·M2V_LAT + V2V_LAT + ADD_LAT (6 at defaults).
- Cycles per column: T_col = ITER_NUM·T_it + 2 (14 at defaults).
- start sampled at edge 0:
  - LOAD in cycle 1.
  - col_valid for column k in cycle T_col·(k+1).
  - done in cycle DIMENSION·T_col + 1 (225 at defaults).
  - IDLE in the following cycle.
- start may be reasserted in the cycle after done (the IDLE cycle). There is no back-to-back start during DONE.

## Structure
- Package mrd_pkg:
  - state enumeration type mrd_state_t
  - default latency constants MRD_M2V_LAT, MRD_V2V_LAT, MRD_ADD_LAT
  - function computing the counter width from the largest latency
- One sub-module: mrd_lat_timer, a loadable down-counter with load/value/zero flag. It is instantiated once and reloaded on every state entry.
- Column and iteration counters plus the FSM stay in mrd_inv_ctrl.

## Test plan
- Reset then idle: rst=1 for 3 cycles → every output 0, state IDLE. start held 0 → no change over 50 cycles.
- Full run at defaults: start pulse at cycle 0 →
  - col_valid at cycles 14, 28, …, 224 with col_idx 0…15
  - done at cycle 225 only
  - busy high over cycles 1–225
- Select sequence for column 0 at defaults:
  - slc_sig2 = 0,0,0,1,1,1,1,0,0,1,1,1,1,0 over cycles 1–14
  - slc_sig1 = 0 over cycles 1–6, 1 over cycles 7–14
  - slc_sig1 returns to 0 at cycle 15 (LOAD of column 1)
- Parameter sweep: ITER_NUM=1, M2V_LAT=3, V2V_LAT=2, ADD_LAT=2, DIMENSION=4 → T_col=12, col_valid at 12/24/36/48, done at 49.
- Abort and restart: abort at cycle 40 → IDLE at cycle 41 with outputs 0. A new start at 41 restarts from col_idx=0, with the first col_valid at cycle 55.
- Ignored start and mid-run reset:
  - start pulses during busy → timing identical to the single-start run.
  - rst at cycle 100 → outputs 0 at cycle 101, no done strobe.
